// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: one-at-a-time CPU request/response sequencer for a registered-read RAM port.
// Define MMIO_EN to decode the I/O window (switches/LEDs) at IO_BASE..10'h3FF instead of the RAM.
module mem_port_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] IO_BASE = 10'h3F0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [9:0]        sw_in,
  output logic [9:0]        led_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic we_q;
  logic io_hit;
  logic [DATA_W-1:0] io_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        we_q      <= req_we;
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
      end
      if (state == WAIT)
        rsp_rdata <= io_hit ? (we_q ? mem_wdata : io_rdata) : mem_rdata;
    end
  end
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    state_nx  = state == IDLE  ? (req_valid ? ISSUE : IDLE) :
                state == ISSUE ? WAIT :
                state == WAIT  ? RESP :
                                 (rsp_ready ? IDLE : RESP);
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    mem_en    = state == ISSUE && we_q && !io_hit && !reset;
  end
`ifdef MMIO_EN
  assign io_hit   = mem_addr >= IO_BASE;
  assign io_rdata = mem_addr == IO_BASE                 ? DATA_W'(sw_in)   :
                    mem_addr == IO_BASE + ADDR_W'(1)    ? DATA_W'(led_out) : '0;
  always_ff @(posedge clk) begin
    if (reset)
      led_out <= '0;
    else if (state == ISSUE && we_q && mem_addr == IO_BASE + ADDR_W'(1))
      led_out <= mem_wdata[9:0];
  end
`else
  logic unused_sw;
  assign unused_sw = ^sw_in;
  assign io_hit    = 1'b0;
  assign io_rdata  = '0;
  assign led_out   = '0;
`endif
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed checks of mem_port_ctrl against a write-through registered-read RAM model.
module tb_mem_port_ctrl;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [9:0] req_addr = 0, sw_in = 0;
  logic [15:0] req_wdata = 0;
  logic req_ready, rsp_valid, mem_en;
  logic [15:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [9:0] mem_addr, led_out;
  logic [15:0] ram [1024];
  int total = 0, bad = 0;
  mem_port_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ready(rsp_ready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sw_in(sw_in), .led_out(led_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_en ? mem_wdata : ram[mem_addr];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
    ram[10'h005] = 16'h0008;
    tick; tick;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk("rst_mem_addr", mem_addr, 10'h000);
    chk("rst_led_out", led_out, 10'h000);
    reset = 0;
    tick;
    req_valid = 1; req_we = 0; req_addr = 10'h005; rsp_ready = 1;
    tick;
    req_valid = 0;
    chk("ld_issue_valid", rsp_valid, 1'b0);
    chk("ld_issue_en", mem_en, 1'b0);
    chk("ld_issue_ready", req_ready, 1'b0);
    chk("ld_issue_addr", mem_addr, 10'h005);
    tick;
    chk("ld_wait_valid", rsp_valid, 1'b0);
    chk("ld_wait_en", mem_en, 1'b0);
    tick;
    chk("ld_resp_valid", rsp_valid, 1'b1);
    chk("ld_resp_rdata", rsp_rdata, 16'h0008);
    chk("ld_resp_en", mem_en, 1'b0);
    tick;
    chk("ld_idle_ready", req_ready, 1'b1);
    chk("ld_idle_valid", rsp_valid, 1'b0);
    req_valid = 1; req_we = 1; req_addr = 10'h020; req_wdata = 16'hBEEF;
    tick;
    req_valid = 0;
    chk("st_issue_en", mem_en, 1'b1);
    chk("st_issue_addr", mem_addr, 10'h020);
    chk("st_issue_wdata", mem_wdata, 16'hBEEF);
    tick;
    chk("st_wait_en", mem_en, 1'b0);
    tick;
    chk("st_resp_valid", rsp_valid, 1'b1);
    chk("st_resp_rdata", rsp_rdata, 16'hBEEF);
    chk("st_resp_en", mem_en, 1'b0);
    tick;
    chk("st_idle_ready", req_ready, 1'b1);
    req_valid = 1; req_we = 0; req_addr = 10'h020; rsp_ready = 0;
    tick;
    req_valid = 0;
    tick; tick;
    chk("bp_resp_valid", rsp_valid, 1'b1);
    chk("bp_resp_rdata", rsp_rdata, 16'hBEEF);
    for (int i = 0; i < 10; i++) begin
      req_valid = (i == 3); req_addr = 10'h005; req_we = 0;
      tick;
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_rdata", rsp_rdata, 16'hBEEF);
      chk("bp_hold_ready", req_ready, 1'b0);
    end
    req_valid = 0; rsp_ready = 1;
    tick;
    chk("bp_release_ready", req_ready, 1'b1);
    chk("bp_release_valid", rsp_valid, 1'b0);
    chk("bp_no_accept_addr", mem_addr, 10'h020);
`ifdef MMIO_EN
    req_valid = 1; req_we = 1; req_addr = 10'h3F1; req_wdata = 16'h03FF;
    tick;
    req_valid = 0;
    chk("io_st_issue_en", mem_en, 1'b0);
    tick;
    chk("io_st_led", led_out, 10'h3FF);
    chk("io_st_wait_en", mem_en, 1'b0);
    tick;
    chk("io_st_rdata", rsp_rdata, 16'h03FF);
    chk("io_st_ram_untouched", ram[10'h3F1], 16'h0000);
    tick;
    sw_in = 10'h155;
    req_valid = 1; req_we = 0; req_addr = 10'h3F0;
    tick;
    req_valid = 0;
    tick; tick;
    chk("io_sw_rdata", rsp_rdata, 16'h0155);
    tick;
    req_valid = 1; req_we = 0; req_addr = 10'h3F5;
    tick;
    req_valid = 0;
    tick; tick;
    chk("io_hole_valid", rsp_valid, 1'b1);
    chk("io_hole_rdata", rsp_rdata, 16'h0000);
    tick;
`else
    req_valid = 1; req_we = 1; req_addr = 10'h3F1; req_wdata = 16'h1234;
    tick;
    req_valid = 0;
    chk("win_st_en", mem_en, 1'b1);
    chk("win_st_addr", mem_addr, 10'h3F1);
    tick;
    chk("win_st_wait_en", mem_en, 1'b0);
    tick;
    chk("win_st_rdata", rsp_rdata, 16'h1234);
    chk("win_st_led", led_out, 10'h000);
    tick;
    req_valid = 1; req_we = 0; req_addr = 10'h3F1;
    tick;
    req_valid = 0;
    tick; tick;
    chk("win_ld_valid", rsp_valid, 1'b1);
    chk("win_ld_rdata", rsp_rdata, 16'h1234);
    tick;
`endif
    req_valid = 1; req_we = 1; req_addr = 10'h040; req_wdata = 16'hAAAA;
    tick;
    req_valid = 0;
    reset = 1;
    #1;
    chk("rm_issue_en", mem_en, 1'b0);
    tick;
    reset = 0;
    chk("rm_ready", req_ready, 1'b1);
    chk("rm_valid", rsp_valid, 1'b0);
    chk("rm_addr", mem_addr, 10'h000);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rm_no_rsp", rsp_valid, 1'b0);
    end
    chk("rm_ram_kept", ram[10'h040], 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Request/response controller between the CPU load/store path and one port of the 1K×16 dual-port block RAM. It accepts one memory transaction at a time over a valid/ready handshake and sequences the RAM's one-cycle registered read latency. It returns read data, or a write acknowledge, over a second valid/ready handshake. A small memory-mapped I/O window at the top of the address space is decoded here and is never forwarded to the RAM.

## Interface
- ADDR_W, 10, word address width; matches the 1024-word RAM.
- DATA_W, 16, word width.
- IO_BASE, 10'h3F0, first address of the I/O window; the window runs from IO_BASE to 10'h3FF.

- clk  in  1  system clock; all logic is on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU presents a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  controller can accept a request.
- rsp_valid  out  1  response available.
- rsp_rdata  out  DATA_W  load data; for a store, the stored word.
- rsp_ready  in  1  CPU consumes the response.
- mem_en  out  1  RAM write enable; connects to the port's en.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM registered output.
- sw_in  in  10  board switches.
- led_out  out  10  board LEDs.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid is high, latch we/addr/wdata into registers and go to ISSUE.
- ISSUE: mem_addr and mem_wdata come from the latched registers.
  - mem_en = we & ~io_hit & ~reset.
  - Next state is WAIT.
- WAIT: capture the response word into rsp_rdata, then go to RESP.
  - RAM load: capture mem_rdata.
  - RAM store: capture mem_rdata, which equals the written data because the RAM's write-through returns it.
  - I/O access: capture the I/O read value, or wdata for an I/O store.
- RESP: rsp_valid=1, and rsp_rdata is held stable. When rsp_ready is high, go to IDLE.
- req_ready is 1 only in IDLE. A request is never accepted while a response is pending, so at most one transaction is in flight.
- mem_addr and mem_wdata keep their last latched values outside ISSUE. mem_en is 0 in every state except ISSUE.
- io_hit = (addr >= IO_BASE), using an unsigned compare on the latched address.
- I/O map when MMIO_EN is defined:
  - IO_BASE+0: read returns {6'b0, sw_in}; writes are ignored.
  - IO_BASE+1: read returns {6'b0, led_out}; a write loads led_out from wdata[9:0].
  - Every other window address reads 16'h0000, and writes to it are dropped.
- Address 10'h3FF is the highest address. There is no wrap and no address arithmetic.

## Timing
- Reset is sampled on posedge and sets: state=IDLE, rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_wdata=0, led_out=0.
- Outputs after reset: req_ready=1, mem_en=0.
- Load latency: if the request is accepted at edge 0, then ISSUE is cycle 1, WAIT is cycle 2, and rsp_valid rises after edge 3.
- Store latency: the RAM write happens at edge 2, and the acknowledge appears on the same schedule as a load.
- Minimum request-to-request spacing is 4 cycles, reached when rsp_ready is held high. Holding rsp_ready low stalls the FSM in RESP indefinitely.
- Reset during a transaction aborts it, and no response is produced. A write in ISSUE is suppressed if reset is high in that cycle, because mem_en is gated by ~reset.
- req_valid and rsp_ready high in the same cycle: in IDLE only req_valid matters; in RESP only rsp_ready matters.

## Configuration
- MMIO_EN defined: the I/O window is decoded as described above. No RAM write ever targets IO_BASE..10'h3FF.
- MMIO_EN undefined:
  - io_hit is forced to 0, and every address, including the window, goes to RAM.
  - led_out is tied to 0, and sw_in is unused.

## Test plan
- Load after reset: RAM[10'h005]=16'h0008. Request load at 5 with rsp_ready=1 → rsp_valid high exactly 3 cycles after acceptance with rsp_rdata=16'h0008, and mem_en stays 0 throughout.
- Store then load: store 16'hBEEF to 10'h020 → mem_en=1 for exactly 1 cycle with mem_addr=10'h020. The acknowledge returns 16'hBEEF, and a following load of 10'h020 returns 16'hBEEF.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_rdata stay stable, req_ready=0 throughout, and a req_valid pulse in that window is not accepted.
- MMIO (MMIO_EN): store 16'h03FF to 10'h3F1 → led_out=10'h3FF and mem_en never asserts. Load 10'h3F0 with sw_in=10'h155 → rsp_rdata=16'h0155. Load 10'h3F5 → 16'h0000.
- Without MMIO_EN: store 16'h1234 to 10'h3F1 → mem_en pulses and led_out stays 0. A load of 10'h3F1 returns 16'h1234.
- Reset mid-op: assert reset in the ISSUE cycle of a store to 10'h040 holding 16'h0000, with data 16'hAAAA → mem_en=0 in that cycle, RAM[10'h040] stays 16'h0000, rsp_valid never rises, and req_ready=1 after reset.
